b_decode: RTL and testbench

B_DECODE -- requirements
Module: b_decode

---
 rtl/b_code_pkg.sv | 54 +++++
 rtl/b_decode_if.sv | 31 +++
 rtl/b_pulse_meas.sv | 80 ++++++++
 rtl/b_decode.sv | 158 +++++++++++++++
 tb/tb_b_decode.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/b_code_pkg.sv
// Shared definitions for the IRIG-B decoder.
// Contents: symbol encoding, FSM state encoding, pulse-width thresholds
// (tenths of a millisecond, turned into clock counts via ms_x10_to_cnt),
// frame geometry, BCD field bit positions and a P-marker position helper.
package b_code_pkg;

  typedef enum logic [1:0] {
    SYM_ZERO = 2'd0,
    SYM_ONE  = 2'd1,
    SYM_P    = 2'd2,
    SYM_ERR  = 2'd3
  } sym_t;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_ONE_P = 2'd1,
    ST_LOCK  = 2'd2
  } dec_state_t;

  localparam int unsigned WIDTH_CNT_W = 24;
  localparam int unsigned LOS_CNT_W   = 32;
  localparam int unsigned FRAME_LEN   = 100;
  localparam int unsigned POS_W       = 7;

  // Class boundaries in tenths of a millisecond.
  localparam longint unsigned MS_X10_MIN  = 64'd10;
  localparam longint unsigned MS_X10_ZERO = 64'd35;
  localparam longint unsigned MS_X10_ONE  = 64'd65;
  localparam longint unsigned MS_X10_MAX  = 64'd95;

  // BCD field start bits within the frame, LSB first on the wire.
  localparam int unsigned SEC_U  = 1;
  localparam int unsigned SEC_T  = 6;
  localparam int unsigned MIN_U  = 10;
  localparam int unsigned MIN_T  = 15;
  localparam int unsigned HOUR_U = 20;
  localparam int unsigned HOUR_T = 25;
  localparam int unsigned DAY_U  = 30;
  localparam int unsigned DAY_T  = 35;
  localparam int unsigned DAY_H  = 40;
  localparam int unsigned YEAR_U = 50;
  localparam int unsigned YEAR_T = 55;

  function automatic longint unsigned ms_x10_to_cnt(input longint unsigned clk_hz,
                                                   input longint unsigned ms_x10);
    return (clk_hz * ms_x10) / 64'd10000;
  endfunction

  // Marker positions: Pr at 0 and P1..P0 at 9, 19, ..., 99.
  function automatic logic is_p_pos(input logic [POS_W-1:0] p);
    return (p == 7'd0) || ((p % 7'd10) == 7'd9);
  endfunction

endpackage

// File: rtl/b_decode_if.sv
// Bus bundle between the IRIG-B decoder and its consumer.
// master (decoder): input ex_bcode_signal; outputs sym_valid, sym, locked,
//   time_valid, sec_bcd, min_bcd, hour_bcd, day_bcd, year_bcd, frame_err.
// slave (consumer): the mirror image.
interface b_decode_if;
  import b_code_pkg::*;

  logic        ex_bcode_signal;
  logic        sym_valid;
  sym_t        sym;
  logic        locked;
  logic        time_valid;
  logic [7:0]  sec_bcd;
  logic [7:0]  min_bcd;
  logic [7:0]  hour_bcd;
  logic [11:0] day_bcd;
  logic [7:0]  year_bcd;
  logic        frame_err;

  modport master (
    input  ex_bcode_signal,
    output sym_valid, sym, locked, time_valid,
    output sec_bcd, min_bcd, hour_bcd, day_bcd, year_bcd, frame_err
  );

  modport slave (
    output ex_bcode_signal,
    input  sym_valid, sym, locked, time_valid,
    input  sec_bcd, min_bcd, hour_bcd, day_bcd, year_bcd, frame_err
  );
endinterface

// File: rtl/b_pulse_meas.sv
// IRIG-B pulse measurement: 2-FF synchronizer, edge detect, saturating
// high-time counter, width classifier and loss-of-signal detector.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   bcode_in     : raw asynchronous DC level code
//   meas_valid   : one-cycle strobe, one cycle after the synchronized fall
//   meas_sym     : classification of the high time, valid with meas_valid
//   los          : one-cycle strobe when no rising edge for LOS_MS
module b_pulse_meas
  import b_code_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 125_000_000,
  parameter int unsigned LOS_MS      = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bcode_in,
  output logic meas_valid,
  output sym_t meas_sym,
  output logic los
);

  localparam logic [WIDTH_CNT_W-1:0] TH_MIN  = WIDTH_CNT_W'(ms_x10_to_cnt(64'(CLK_FREQ_HZ), MS_X10_MIN));
  localparam logic [WIDTH_CNT_W-1:0] TH_ZERO = WIDTH_CNT_W'(ms_x10_to_cnt(64'(CLK_FREQ_HZ), MS_X10_ZERO));
  localparam logic [WIDTH_CNT_W-1:0] TH_ONE  = WIDTH_CNT_W'(ms_x10_to_cnt(64'(CLK_FREQ_HZ), MS_X10_ONE));
  localparam logic [WIDTH_CNT_W-1:0] TH_MAX  = WIDTH_CNT_W'(ms_x10_to_cnt(64'(CLK_FREQ_HZ), MS_X10_MAX));
  localparam logic [LOS_CNT_W-1:0]   LOS_CNT = LOS_CNT_W'(ms_x10_to_cnt(64'(CLK_FREQ_HZ), 64'(LOS_MS) * 64'd10));

  logic                   sync_1, sync_2, level_q;
  logic                   rise, fall, fall_q;
  logic [WIDTH_CNT_W-1:0] width_cnt;
  logic [LOS_CNT_W-1:0]   los_cnt;

  assign rise = sync_2 & ~level_q;
  assign fall = ~sync_2 & level_q;

  // level_q lags sync_2 by one cycle, so counting on level_q also counts the
  // fall cycle: width_cnt equals the number of synchronized high cycles by
  // the time fall_q is set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      level_q   <= 1'b0;
      fall_q    <= 1'b0;
      width_cnt <= '0;
      los_cnt   <= '0;
    end else begin
      sync_1  <= bcode_in;
      sync_2  <= sync_1;
      level_q <= sync_2;
      fall_q  <= fall;
      if (rise)
        width_cnt <= '0;
      else if (level_q && (width_cnt != '1))
        width_cnt <= width_cnt + 1'b1;
      // Parks at LOS_CNT so the LOS strobe fires once per silent stretch.
      if (rise)
        los_cnt <= '0;
      else if (los_cnt != LOS_CNT)
        los_cnt <= los_cnt + 1'b1;
    end
  end

  assign los        = !rise && (los_cnt == LOS_CNT - 32'd1);
  assign meas_valid = fall_q;

  always_comb begin
    meas_sym = SYM_ERR;
    if (width_cnt < TH_MIN)
      meas_sym = SYM_ERR;
    else if (width_cnt < TH_ZERO)
      meas_sym = SYM_ZERO;
    else if (width_cnt < TH_ONE)
      meas_sym = SYM_ONE;
    else if (width_cnt < TH_MAX)
      meas_sym = SYM_P;
  end

endmodule

// File: rtl/b_decode.sv
// IRIG-B time code decoder: frame alignment FSM and BCD field extraction on
// top of b_pulse_meas.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : b_decode_if.master (ex_bcode_signal in; sym_valid, sym,
//                locked, time_valid, *_bcd fields, frame_err out)
// Build option: define B_DECODE_YEAR_EN to decode year_bcd; otherwise it is
// tied to zero and the year register is not built.
//
// state    | meaning
// ST_HUNT  | searching for the first of two consecutive P markers
// ST_ONE_P | one P seen; a second P (Pr) aligns the frame at position 0
// ST_LOCK  | aligned; pos is the position of the last accepted symbol
module b_decode
  import b_code_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 125_000_000,
  parameter int unsigned LOS_MS      = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  b_decode_if.master   bus
);

  dec_state_t           state, state_n;
  logic [POS_W-1:0]     pos, pos_n, pos_cur;
  logic [FRAME_LEN-1:0] frame, frame_n;
  logic                 err_n, tv_n;
  logic                 meas_valid, los;
  sym_t                 meas_sym;

  logic                 sym_valid_q, time_valid_q, frame_err_q;
  sym_t                 sym_q;
  logic [7:0]           sec_q, min_q, hour_q;
  logic [11:0]          day_q;

  b_pulse_meas #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .LOS_MS      (LOS_MS)
  ) u_meas (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcode_in   (bus.ex_bcode_signal),
    .meas_valid (meas_valid),
    .meas_sym   (meas_sym),
    .los        (los)
  );

  assign pos_cur = (pos == 7'(FRAME_LEN - 1)) ? '0 : pos + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_HUNT;
      pos   <= '0;
      frame <= '0;
    end else begin
      state <= state_n;
      pos   <= pos_n;
      frame <= frame_n;
    end
  end

  // LOS wins over a coincident symbol. Pr (position 0) is a marker as well,
  // so it is accepted as P when the frame wraps.
  always_comb begin
    state_n = state;
    pos_n   = pos;
    frame_n = frame;
    err_n   = 1'b0;
    tv_n    = 1'b0;
    if (los) begin
      err_n   = (state == ST_LOCK);
      state_n = ST_HUNT;
    end else if (meas_valid) begin
      unique case (state)
        ST_HUNT: begin
          if (meas_sym == SYM_P)
            state_n = ST_ONE_P;
        end
        ST_ONE_P: begin
          if (meas_sym == SYM_P) begin
            state_n = ST_LOCK;
            pos_n   = '0;
          end else begin
            state_n = ST_HUNT;
          end
        end
        ST_LOCK: begin
          if ((meas_sym == SYM_ERR) || ((meas_sym == SYM_P) != is_p_pos(pos_cur))) begin
            err_n   = 1'b1;
            state_n = ST_HUNT;
          end else begin
            pos_n = pos_cur;
            if (meas_sym != SYM_P)
              frame_n[pos_cur] = (meas_sym == SYM_ONE);
            tv_n = (pos_cur == 7'(FRAME_LEN - 1));
          end
        end
        default: state_n = ST_HUNT;
      endcase
    end
  end

  always_comb begin
    bus.locked = (state == ST_LOCK);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sym_valid_q  <= 1'b0;
      sym_q        <= SYM_ZERO;
      time_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      sec_q        <= '0;
      min_q        <= '0;
      hour_q       <= '0;
      day_q        <= '0;
    end else begin
      sym_valid_q  <= meas_valid;
      time_valid_q <= tv_n;
      frame_err_q  <= err_n;
      if (meas_valid)
        sym_q <= meas_sym;
      // Position 99 is a marker, so frame already holds the full frame here.
      if (tv_n) begin
        sec_q  <= {1'b0, frame[SEC_T +: 3], frame[SEC_U +: 4]};
        min_q  <= {1'b0, frame[MIN_T +: 3], frame[MIN_U +: 4]};
        hour_q <= {2'b0, frame[HOUR_T +: 2], frame[HOUR_U +: 4]};
        day_q  <= {2'b0, frame[DAY_H +: 2], frame[DAY_T +: 4], frame[DAY_U +: 4]};
      end
    end
  end

`ifdef B_DECODE_YEAR_EN
  logic [7:0] year_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      year_q <= '0;
    else if (tv_n)
      year_q <= {frame[YEAR_T +: 4], frame[YEAR_U +: 4]};
  end

  assign bus.year_bcd = year_q;
`else
  assign bus.year_bcd = 8'h00;
`endif

  assign bus.sym_valid  = sym_valid_q;
  assign bus.sym        = sym_q;
  assign bus.time_valid = time_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.sec_bcd    = sec_q;
  assign bus.min_bcd    = min_q;
  assign bus.hour_bcd   = hour_q;
  assign bus.day_bcd    = day_q;

endmodule

// File: tb/tb_b_decode.sv
// Scoreboard bench for b_decode. The clock rate parameter is scaled down to
// 4 kHz so 1 ms = 4 cycles and a 10 ms symbol = 40 cycles; thresholds are
// then 4 / 14 / 26 / 38 counts and LOS is 48 cycles.
// The driver pushes the expected symbol, flags and due cycle when it drives
// each falling edge; the monitor pops on every sym_valid. Expected year
// follows B_DECODE_YEAR_EN.
module tb_b_decode;
  import b_code_pkg::*;

  localparam int unsigned CLK_HZ = 4000;
  localparam int PERIOD  = 40;
  localparam int ZERO_HI = 8;   // 2 ms
  localparam int ONE_HI  = 20;  // 5 ms
  localparam int P_HI    = 32;  // 8 ms
  localparam int SHORT_HI = 2;  // 0.5 ms
  localparam int LONG_HI  = 39; // ~9.8 ms
  // 2 synchronizer stages + 2 cycles after the synchronized fall.
  localparam int LATENCY = 4;

  localparam logic [7:0]  EXP_SEC  = 8'h18;
  localparam logic [7:0]  EXP_MIN  = 8'h01;
  localparam logic [7:0]  EXP_HOUR = 8'h00;
  localparam logic [11:0] EXP_DAY  = 12'h105;
`ifdef B_DECODE_YEAR_EN
  localparam logic [7:0]  EXP_YEAR = 8'h24;
`else
  localparam logic [7:0]  EXP_YEAR = 8'h00;
`endif

  typedef struct {
    logic [1:0] sym;
    int         due;
    bit         tv;
    bit         err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   los_seen = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  logic [99:0] fb;

  b_decode_if bus();

  b_decode #(
    .CLK_FREQ_HZ (CLK_HZ),
    .LOS_MS      (12)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_sym_valid"},  32'(bus.sym_valid), 0);
    chk({tag, "_sym"},        32'(bus.sym), 0);
    chk({tag, "_locked"},     32'(bus.locked), 0);
    chk({tag, "_time_valid"}, 32'(bus.time_valid), 0);
    chk({tag, "_frame_err"},  32'(bus.frame_err), 0);
    chk({tag, "_sec"},        32'(bus.sec_bcd), 0);
    chk({tag, "_min"},        32'(bus.min_bcd), 0);
    chk({tag, "_hour"},       32'(bus.hour_bcd), 0);
    chk({tag, "_day"},        32'(bus.day_bcd), 0);
    chk({tag, "_year"},       32'(bus.year_bcd), 0);
  endtask

  task automatic chk_fields(input string tag);
    chk({tag, "_sec"},  32'(bus.sec_bcd),  32'(EXP_SEC));
    chk({tag, "_min"},  32'(bus.min_bcd),  32'(EXP_MIN));
    chk({tag, "_hour"}, 32'(bus.hour_bcd), 32'(EXP_HOUR));
    chk({tag, "_day"},  32'(bus.day_bcd),  32'(EXP_DAY));
    chk({tag, "_year"}, 32'(bus.year_bcd), 32'(EXP_YEAR));
  endtask

  // Monitor: every sym_valid must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.sym_valid) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sym_unexpected: got sym %0d with nothing expected (cycle %0d)", bus.sym, cyc);
        end else begin
          mon_e = sb_q.pop_front();
          chk("sym", 32'(bus.sym), 32'(mon_e.sym));
          chk("sym_cycle", 32'(cyc), 32'(mon_e.due));
          chk("time_valid", 32'(bus.time_valid), 32'(mon_e.tv));
          chk("frame_err", 32'(bus.frame_err), 32'(mon_e.err));
          if (mon_e.tv)
            chk_fields("tv");
        end
      end else begin
        if (bus.frame_err)
          los_seen++;
        if (bus.time_valid) begin
          n_checks++;
          n_fail++;
          $display("FAIL tv_alone: got time_valid=1 without sym_valid, required 0 (cycle %0d)", cyc);
        end
      end
    end
  end

  task automatic send_raw(input int high, input int low, input logic [1:0] s,
                          input bit tv, input bit err);
    bus.ex_bcode_signal = 1'b1;
    repeat (high) @(negedge clk);
    bus.ex_bcode_signal = 1'b0;
    sb_q.push_back('{sym: s, due: cyc + LATENCY, tv: tv, err: err});
    repeat (low) @(negedge clk);
  endtask

  task automatic send_pos(input int p, input bit tv, input bit err);
    if (p == 0 || (p % 10) == 9)
      send_raw(P_HI, PERIOD - P_HI, SYM_P, tv, err);
    else if (fb[p])
      send_raw(ONE_HI, PERIOD - ONE_HI, SYM_ONE, tv, err);
    else
      send_raw(ZERO_HI, PERIOD - ZERO_HI, SYM_ZERO, tv, err);
  endtask

  int los_base;

  initial begin
    // 00:01:18, day 105, year 24
    fb = '0;
    fb[4] = 1'b1;  fb[6] = 1'b1;  fb[10] = 1'b1;
    fb[30] = 1'b1; fb[32] = 1'b1; fb[40] = 1'b1;
    fb[52] = 1'b1; fb[56] = 1'b1;

    bus.ex_bcode_signal = 1'b0;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Symbol classes while hunting: no frame_err for ERR when unlocked.
    send_raw(ZERO_HI, PERIOD - ZERO_HI, SYM_ZERO, 0, 0);
    send_raw(ONE_HI, PERIOD - ONE_HI, SYM_ONE, 0, 0);
    send_raw(P_HI, PERIOD - P_HI, SYM_P, 0, 0);
    send_raw(SHORT_HI, PERIOD - SHORT_HI, SYM_ERR, 0, 0);
    send_raw(LONG_HI, PERIOD - LONG_HI, SYM_ERR, 0, 0);
    repeat (8) @(negedge clk);
    chk("locked_idle", 32'(bus.locked), 0);

    // Frame 1 (P99 -> ONE_P), frame 2 (Pr -> LOCK, time_valid at P0).
    for (int p = 0; p < 100; p++) send_pos(p, 0, 0);
    chk("locked_one_p", 32'(bus.locked), 0);
    send_pos(0, 0, 0);
    chk("locked_double_p", 32'(bus.locked), 1);
    for (int p = 1; p < 100; p++) send_pos(p, p == 99, 0);
    chk("locked_frame2", 32'(bus.locked), 1);

    // Frame 3: ZERO in place of P at 39 -> frame_err, no time_valid.
    for (int p = 0; p < 100; p++) begin
      if (p == 39)
        send_raw(ZERO_HI, PERIOD - ZERO_HI, SYM_ZERO, 0, 1);
      else
        send_pos(p, 0, 0);
      if (p == 40)
        chk("locked_after_inject", 32'(bus.locked), 0);
    end

    // Frame 4: relock on P99/Pr, full frame.
    send_pos(0, 0, 0);
    chk("locked_relock", 32'(bus.locked), 1);
    for (int p = 1; p < 100; p++) send_pos(p, p == 99, 0);

    // Frame 5: ~9.8 ms pulse at position 5 while locked.
    for (int p = 0; p < 100; p++) begin
      if (p == 5)
        send_raw(LONG_HI, PERIOD - LONG_HI, SYM_ERR, 0, 1);
      else
        send_pos(p, 0, 0);
      if (p == 6)
        chk("locked_after_err", 32'(bus.locked), 0);
    end

    // Frame 6: relock, then hold the input low past LOS.
    for (int p = 0; p <= 20; p++) send_pos(p, 0, 0);
    chk("locked_before_los", 32'(bus.locked), 1);
    los_base = los_seen;
    repeat (52 + 100) @(negedge clk);
    chk("los_pulses", 32'(los_seen - los_base), 1);
    chk("locked_after_los", 32'(bus.locked), 0);
    chk_fields("los_hold");

    // Frame 7 + 8: lock, reset at position 50.
    for (int p = 0; p < 100; p++) send_pos(p, 0, 0);
    for (int p = 0; p <= 50; p++) send_pos(p, 0, 0);
    chk("locked_before_rst", 32'(bus.locked), 1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("midrst");
    rst_n = 1'b1;
    for (int p = 51; p < 100; p++) send_pos(p, 0, 0);
    chk("locked_after_rst", 32'(bus.locked), 0);
    send_pos(0, 0, 0);
    chk("locked_after_rst_relock", 32'(bus.locked), 1);
    for (int p = 1; p < 100; p++) send_pos(p, p == 99, 0);

    repeat (20) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
